// File: rtl/as_verdict_filter_if.sv
// Packet word stream between pipeline stages: one word per cycle while wr is high.
// Latency: none, this is a plain wire bundle.
// Backpressure: rdy is driven by the receiver; the sender only asserts wr while rdy is high.
//
// Signals:
//   data  packet word
//   ctrl  per-word control; non-zero marks header words and the end-of-packet word
//   wr    word strobe
//   rdy   receiver can accept words
interface as_verdict_filter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  // master drives the words, slave returns rdy
  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/as_verdict_filter.sv
// Holds packets until their in-order verdict arrives, stamps the verdict port mask into
// the IO-queue header, then forwards or silently discards the whole packet.
// Latency: out_wr one cycle after a word leaves the packet FIFO; at least one idle cycle between packets.
// Backpressure: forwarded words need out_rdy; dropped words drain at one per cycle regardless;
//   in_rdy falls when either the packet FIFO or the verdict FIFO is nearly full.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   in_if   (slave)          packet words from the input arbiter; in_if.rdy is in_rdy
//   out_if  (master)         registered packet words to the output queues; out_if.rdy is out_rdy
//   verdict_valid/drop/oq    one-cycle verdict for the oldest packet without one
//   verdict_ovf              sticky: a verdict was lost because the verdict FIFO was full
//   pkt_fwd_cnt/pkt_drop_cnt wrapping packet counters, bumped on the end-of-packet word
//
// Build option: define AS_DROP_TO_CPU_EN to redirect dropped packets to CPU_REDIRECT_OQ
// (they still count as drops) instead of discarding them.

// Small show-ahead FIFO: rd_data is the head word whenever empty is low.
module as_vf_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  // One slot of headroom: the writer sees nearly_full before the last slot is taken.
  localparam logic [DEPTH_BITS:0]   NF_CNT   = (DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign nearly_full = (count >= NF_CNT);
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign rd_data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      // simultaneous push and pop leave the occupancy unchanged
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

module as_verdict_filter #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int IN_FIFO_DEPTH_BITS = 5,
  parameter int VERDICT_DEPTH_BITS = 2,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] CPU_REDIRECT_OQ = 8'b10101010,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = {CTRL_WIDTH{1'b1}},
  parameter int IOQ_DST_PORT_POS   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  as_verdict_filter_if.slave           in_if,
  as_verdict_filter_if.master          out_if,
  input  logic                         verdict_valid,
  input  logic                         verdict_drop,
  input  logic [NUM_OUTPUT_QUEUES-1:0] verdict_oq,
  output logic                         verdict_ovf,
  output logic [31:0]                  pkt_fwd_cnt,
  output logic [31:0]                  pkt_drop_cnt
);
`ifdef AS_DROP_TO_CPU_EN
  // dropped packets are sent to the CPU port mask and obey out_rdy like any forward
  localparam bit DISCARD_DROPS = 1'b0;
`else
  // dropped packets are drained from the FIFO and never appear on the output
  localparam bit DISCARD_DROPS = 1'b1;
`endif

  localparam int PF_W = CTRL_WIDTH + DATA_WIDTH;
  localparam int VF_W = 1 + NUM_OUTPUT_QUEUES;

  typedef enum logic [1:0] {
    WAIT_VERDICT = 2'd0,
    HDRS         = 2'd1,
    DATA         = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // packet word FIFO
  logic                  pf_wr;
  logic                  pf_rd;
  logic [PF_W-1:0]       pf_dout;
  logic                  pf_empty;
  logic                  pf_full;
  logic                  pf_nearly_full;
  logic [DATA_WIDTH-1:0] pf_data;
  logic [CTRL_WIDTH-1:0] pf_ctrl;

  // verdict FIFO, entries are {drop, port mask}
  logic                         vf_wr;
  logic                         vf_rd;
  logic [VF_W-1:0]              vf_dout;
  logic                         vf_empty;
  logic                         vf_full;
  logic                         vf_nearly_full;
  logic                         vf_drop;
  logic [NUM_OUTPUT_QUEUES-1:0] vf_oq;

  // verdict of the packet currently being moved
  logic                         cur_drop;
  logic [NUM_OUTPUT_QUEUES-1:0] cur_oq;
  logic                         latch_verdict;
  logic                         discard;
  logic                         word_go;
  logic                         eop_pop;
  logic [DATA_WIDTH-1:0]        data_mod;

  assign pf_wr = in_if.wr && !pf_full;
  assign vf_wr = verdict_valid && !vf_full;

  as_vf_fifo #(.WIDTH(PF_W), .DEPTH_BITS(IN_FIFO_DEPTH_BITS)) u_pkt_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (pf_wr),
    .wr_data     ({in_if.ctrl, in_if.data}),
    .rd_en       (pf_rd),
    .rd_data     (pf_dout),
    .empty       (pf_empty),
    .full        (pf_full),
    .nearly_full (pf_nearly_full)
  );

  as_vf_fifo #(.WIDTH(VF_W), .DEPTH_BITS(VERDICT_DEPTH_BITS)) u_verdict_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (vf_wr),
    .wr_data     ({verdict_drop, verdict_oq}),
    .rd_en       (vf_rd),
    .rd_data     (vf_dout),
    .empty       (vf_empty),
    .full        (vf_full),
    .nearly_full (vf_nearly_full)
  );

  assign {pf_ctrl, pf_data} = pf_dout;
  assign {vf_drop, vf_oq}   = vf_dout;

  assign in_if.rdy = !pf_nearly_full && !vf_nearly_full;

  // A discarded packet drains without waiting on the output; anything sent out needs out_rdy.
  assign discard = cur_drop && DISCARD_DROPS;
  assign word_go = !pf_empty && (discard || out_if.rdy);

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_VERDICT;
    else       state <= state_nxt;
  end

  // The first word of a packet is popped from HDRS rather than together with the
  // verdict, which gives the one idle output cycle between back-to-back packets.
  always_comb begin
    state_nxt     = state;
    vf_rd         = 1'b0;
    pf_rd         = 1'b0;
    latch_verdict = 1'b0;
    eop_pop       = 1'b0;
    case (state)
      WAIT_VERDICT: begin
        // a non-empty packet FIFO means the oldest packet has at least started arriving
        if (!vf_empty && !pf_empty) begin
          vf_rd         = 1'b1;
          latch_verdict = 1'b1;
          state_nxt     = HDRS;
        end
      end
      HDRS: begin
        if (word_go) begin
          pf_rd = 1'b1;
          if (pf_ctrl == '0) state_nxt = DATA;
        end
      end
      DATA: begin
        if (word_go) begin
          pf_rd = 1'b1;
          if (pf_ctrl != '0) begin
            eop_pop   = 1'b1;
            state_nxt = WAIT_VERDICT;
          end
        end
      end
      default: state_nxt = WAIT_VERDICT;
    endcase
  end

  // Only the IO-queue module header carries the destination port field.
  always_comb begin
    data_mod = pf_data;
    if (state == HDRS && pf_ctrl == IO_QUEUE_STAGE_NUM) begin
      data_mod[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] = cur_oq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_drop <= 1'b0;
      cur_oq   <= '0;
    end else if (latch_verdict) begin
      cur_drop <= vf_drop;
      cur_oq   <= vf_drop ? CPU_REDIRECT_OQ : vf_oq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_if.wr   <= 1'b0;
      out_if.data <= '0;
      out_if.ctrl <= '0;
    end else begin
      out_if.wr <= pf_rd && !discard;
      if (pf_rd && !discard) begin
        out_if.data <= data_mod;
        out_if.ctrl <= pf_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_fwd_cnt  <= 32'd0;
      pkt_drop_cnt <= 32'd0;
    end else if (eop_pop) begin
      // redirected drops count as drops too
      if (cur_drop) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      else          pkt_fwd_cnt  <= pkt_fwd_cnt + 32'd1;
    end
  end

  // a verdict arriving at a full verdict FIFO is lost even if one is popped that cycle
  always_ff @(posedge clk) begin
    if (reset)                         verdict_ovf <= 1'b0;
    else if (verdict_valid && vf_full) verdict_ovf <= 1'b1;
  end
endmodule

// File: tb/tb_as_verdict_filter.sv
`timescale 1ns/1ps
module tb_as_verdict_filter;
  localparam int DW = 64;
  localparam int CW = 8;

`ifdef AS_DROP_TO_CPU_EN
  localparam bit DROP_FWD = 1'b1;
`else
  localparam bit DROP_FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  as_verdict_filter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_bus ();
  as_verdict_filter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_bus ();

  logic        verdict_valid = 1'b0;
  logic        verdict_drop = 1'b0;
  logic [7:0]  verdict_oq = 8'h00;
  logic        verdict_ovf;
  logic [31:0] pkt_fwd_cnt;
  logic [31:0] pkt_drop_cnt;

  as_verdict_filter dut (
    .clk           (clk),
    .reset         (reset),
    .in_if         (in_bus),
    .out_if        (out_bus),
    .verdict_valid (verdict_valid),
    .verdict_drop  (verdict_drop),
    .verdict_oq    (verdict_oq),
    .verdict_ovf   (verdict_ovf),
    .pkt_fwd_cnt   (pkt_fwd_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt)
  );

  // packet store, indexed by global packet number
  logic [63:0] pd [0:127][0:31];
  logic [7:0]  pc [0:127][0:31];
  int          plen [0:127];
  int          phdr [0:127];

  logic [63:0] exp_d [$];
  logic [7:0]  exp_c [$];
  int nchk = 0;
  int nfail = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int pnext = 0;
  int vnext = 0;
  int pstart = 0;
  int out_cnt = 0;
  bit rand_done;
  bit bp_done;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // packet: word 0 is the IO-queue header, further headers, payload, non-zero-ctrl EOP
  task automatic gen_pkt(input int p, input int nhdr, input int len);
    plen[p] = len;
    phdr[p] = nhdr;
    for (int j = 0; j < len; j++) begin
      pd[p][j] = {$urandom, $urandom};
      if (j == 0)             pc[p][j] = 8'hff;
      else if (j < nhdr)      pc[p][j] = 8'($urandom_range(1, 254));
      else if (j == len - 1)  pc[p][j] = 8'($urandom_range(1, 254));
      else                    pc[p][j] = 8'h00;
    end
  endtask

  // reference: the verdict decides the whole packet's fate; header words with the
  // IO-queue ctrl code get the port mask written into bits [23:16]
  task automatic model(input int p, input bit drop, input logic [7:0] oq);
    logic [7:0]  port;
    logic [63:0] d;
    port = drop ? 8'hAA : oq;
    if (drop) exp_drop++;
    else      exp_fwd++;
    if (!drop || DROP_FWD) begin
      for (int j = 0; j < plen[p]; j++) begin
        d = pd[p][j];
        if (j < phdr[p] && pc[p][j] == 8'hff)
          d = (d & ~(64'hff << 16)) | (64'(port) << 16);
        exp_d.push_back(d);
        exp_c.push_back(pc[p][j]);
      end
    end
  endtask

  task automatic run_monitor();
    logic [63:0] md;
    logic [7:0]  mc;
    forever begin
      @(negedge clk);
      if (!reset && out_bus.wr) begin
        out_cnt++;
        if (exp_d.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_out: got word %h ctrl %h, required no output", out_bus.data, out_bus.ctrl);
        end else begin
          md = exp_d.pop_front();
          mc = exp_c.pop_front();
          chk("out_data", out_bus.data, md);
          chk("out_ctrl", 64'(out_bus.ctrl), 64'(mc));
        end
      end
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_bus.rdy && t < 3000) begin
      in_bus.wr = 1'b0;
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      nchk++;
      nfail++;
      $display("FAIL in_rdy_timeout: in_rdy stayed 0, required 1 within 3000 cycles");
    end
    in_bus.data = d;
    in_bus.ctrl = c;
    in_bus.wr   = 1'b1;
  endtask

  task automatic send_pkt(input int p);
    for (int j = 0; j < plen[p]; j++) begin
      send_word(pd[p][j], pc[p][j]);
      if (j == 0) pstart = p + 1;
    end
    @(negedge clk);
    in_bus.wr = 1'b0;
  endtask

  task automatic issue_verdict(input bit drop, input logic [7:0] oq, input bit accepted);
    @(negedge clk);
    if (accepted) begin
      model(vnext, drop, oq);
      vnext++;
    end
    verdict_valid = 1'b1;
    verdict_drop  = drop;
    verdict_oq    = oq;
    @(negedge clk);
    verdict_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_d.size()), 64'd0);
    repeat (40) @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fwd_cnt"}, 64'(pkt_fwd_cnt), 64'(exp_fwd));
    chk({tag, "_drop_cnt"}, 64'(pkt_drop_cnt), 64'(exp_drop));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_d.delete();
    exp_c.delete();
    in_bus.wr = 1'b0;
    verdict_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vnext = pnext;
    pstart = pnext;
    exp_fwd = 0;
    exp_drop = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int base;
    int t;
    int ocb;
    in_bus.wr = 1'b0;
    in_bus.data = '0;
    in_bus.ctrl = '0;
    out_bus.rdy = 1'b1;
    fork run_monitor(); join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_wr", 64'(out_bus.wr), 64'd0);
    chk("rst_out_data", out_bus.data, 64'd0);
    chk("rst_out_ctrl", 64'(out_bus.ctrl), 64'd0);
    chk("rst_ovf", 64'(verdict_ovf), 64'd0);
    chk("rst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_rdy", 64'(in_bus.rdy), 64'd1);

    // single forward with zero IO-queue header
    p = pnext++;
    gen_pkt(p, 2, 8);
    pd[p][0] = 64'd0;
    send_pkt(p);
    issue_verdict(1'b0, 8'h04, 1'b1);
    wait_quiet("fwd_drain");
    chk_cnt("fwd");

    // drop with the output stalled, then a normal forward
    out_bus.rdy = DROP_FWD;
    p = pnext++;
    gen_pkt(p, 2, 8);
    send_pkt(p);
    issue_verdict(1'b1, 8'h3c, 1'b1);
    wait_quiet("drop_drain");
    chk_cnt("drop");
    out_bus.rdy = 1'b1;
    p = pnext++;
    gen_pkt(p, 1, 6);
    send_pkt(p);
    issue_verdict(1'b0, 8'h80, 1'b1);
    wait_quiet("after_drop_drain");
    chk_cnt("after_drop");

    // ordering: three packets queued before their verdicts
    for (int i = 0; i < 3; i++) begin
      gen_pkt(pnext, 2, 8);
      send_pkt(pnext);
      pnext++;
    end
    issue_verdict(1'b0, 8'h01, 1'b1);
    issue_verdict(1'b1, 8'h02, 1'b1);
    issue_verdict(1'b0, 8'h10, 1'b1);
    wait_quiet("order_drain");
    chk_cnt("order");

    // backpressure: fill until in_rdy falls, then release with out_rdy toggling every 3 cycles
    base = pnext;
    for (int i = 0; i < 4; i++) gen_pkt(base + i, 2, 8);
    pnext += 4;
    bp_done = 1'b0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 4; i++) send_pkt(base + i);
          end
          begin
            t = 0;
            while (in_bus.rdy && t < 2000) begin
              @(negedge clk);
              t++;
            end
            chk("bp_in_rdy_low", 64'(in_bus.rdy), 64'd0);
            for (int i = 0; i < 4; i++) issue_verdict(1'b0, 8'(1 << i), 1'b1);
          end
        join
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          out_bus.rdy = 1'b1;
          repeat (3) @(negedge clk);
          out_bus.rdy = 1'b0;
          repeat (3) @(negedge clk);
        end
      end
    join
    out_bus.rdy = 1'b1;
    wait_quiet("bp_drain");
    chk_cnt("bp");

    // randomized: verdicts before, during or after their packets, random output stalls
    base = pnext;
    for (int i = 0; i < 24; i++) begin
      t = $urandom_range(1, 3);
      gen_pkt(base + i, t, t + 2 + $urandom_range(0, 10));
    end
    pnext += 24;
    rand_done = 1'b0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 24; i++) send_pkt(base + i);
          end
          begin
            for (int i = 0; i < 24; i++) begin
              int w;
              w = 0;
              repeat ($urandom_range(0, 12)) @(negedge clk);
              // at most two verdicts ahead of the newest started packet
              while (base + i > pstart + 1 && w < 5000) begin
                @(negedge clk);
                w++;
              end
              issue_verdict($urandom_range(0, 2) == 0, 8'($urandom_range(1, 255)), 1'b1);
            end
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_bus.rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_bus.rdy = 1'b1;
    wait_quiet("rand_drain");
    chk_cnt("rand");

    // verdict overflow: depth 4, fifth is lost
    do_reset();
    for (int i = 0; i < 4; i++) issue_verdict(1'b1, 8'h01, 1'b1);
    chk("ovf_at_full", 64'(verdict_ovf), 64'd0);
    issue_verdict(1'b0, 8'h02, 1'b0);
    chk("ovf_set", 64'(verdict_ovf), 64'd1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 64'(verdict_ovf), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(verdict_ovf), 64'd0);

    // reset in the middle of a forwarded packet
    p = pnext++;
    gen_pkt(p, 2, 6);
    send_pkt(p);
    issue_verdict(1'b1, 8'h01, 1'b1);
    wait_quiet("pre_rst_drain");
    chk_cnt("pre_rst");
    p = pnext++;
    gen_pkt(p, 3, 20);
    send_pkt(p);
    ocb = out_cnt;
    issue_verdict(1'b0, 8'h20, 1'b1);
    t = 0;
    while (out_cnt < ocb + 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("mid_pkt_started", 64'(out_cnt >= ocb + 3), 64'd1);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_rst_out_wr", 64'(out_bus.wr), 64'd0);
    end
    chk_cnt("mid_rst");
    chk("mid_rst_ovf", 64'(verdict_ovf), 64'd0);
    p = pnext++;
    gen_pkt(p, 2, 7);
    send_pkt(p);
    issue_verdict(1'b0, 8'h40, 1'b1);
    wait_quiet("post_rst_drain");
    chk_cnt("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
